// File: rtl/modexp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : modexp_scheduler                                                |
// | Purpose  : Two-requester modular exponentiation scheduler. Round-robin     |
// |            arbitrates req0/req1, then runs left-to-right square-and-       |
// |            multiply, issuing every product to one shared external modular  |
// |            multiplier over a start/done handshake.                         |
// | Ports    : clk, reset (async, active-high)                                 |
// |            req0/req1, base0/1, exp0/1, mod0/1  - requester side inputs     |
// |            gnt0/gnt1                           - one-cycle grant pulses    |
// |            done, result, result_id, err, busy  - completion/status         |
// |            mm_start, mm_a, mm_b, mm_n          - multiplier request        |
// |            mm_done, mm_result                  - multiplier response       |
// |            cycles                              - job cycle count           |
// | Config   : MODEXP_PERF_CNT_EN - when defined, builds the cycle counter;    |
// |            otherwise cycles is tied to 0.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module modexp_scheduler #(
  parameter int WIDTH  = 16,
  parameter int EWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [WIDTH-1:0]  base0,
  input  logic [WIDTH-1:0]  base1,
  input  logic [EWIDTH-1:0] exp0,
  input  logic [EWIDTH-1:0] exp1,
  input  logic [WIDTH-1:0]  mod0,
  input  logic [WIDTH-1:0]  mod1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              result_id,
  output logic              err,
  output logic              busy,
  output logic              mm_start,
  output logic [WIDTH-1:0]  mm_a,
  output logic [WIDTH-1:0]  mm_b,
  output logic [WIDTH-1:0]  mm_n,
  input  logic              mm_done,
  input  logic [WIDTH-1:0]  mm_result,
  output logic [31:0]       cycles
);

  localparam int IW = (EWIDTH > 1) ? $clog2(EWIDTH) : 1;

  localparam logic [IW-1:0]    c_top_idx = IW'(EWIDTH - 1);
  localparam logic [IW-1:0]    c_idx_one = IW'(1);
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

  localparam logic [3:0] c_st_idle  = 4'd0;
  localparam logic [3:0] c_st_check = 4'd1;
  localparam logic [3:0] c_st_scan  = 4'd2;
  localparam logic [3:0] c_st_sqr   = 4'd3;
  localparam logic [3:0] c_st_sqr_w = 4'd4;
  localparam logic [3:0] c_st_mul   = 4'd5;
  localparam logic [3:0] c_st_mul_w = 4'd6;
  localparam logic [3:0] c_st_next  = 4'd7;
  localparam logic [3:0] c_st_done  = 4'd8;

  logic [3:0]        r_state;
  logic [3:0]        w_next_state;
  logic [WIDTH-1:0]  r_base;
  logic [WIDTH-1:0]  r_n;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_result;
  logic [EWIDTH-1:0] r_exp;
  logic [IW-1:0]     r_idx;
  logic              r_id;
  logic              r_rr;
  logic              r_result_id;
  logic              r_err;
  logic              w_take;
  logic              w_pick1;
  logic              w_bit;

  // r_rr set means requester 1 wins the next tie.
  assign w_pick1 = req1 & (~req0 | r_rr);
  // Grants are combinational in IDLE; reset gates them so every output is 0
  // while reset is held.
  assign w_take  = (r_state == c_st_idle) & (req0 | req1) & ~reset;
  assign w_bit   = r_exp[r_idx];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (w_take) w_next_state = c_st_check;
      c_st_check: begin
        if ((r_n == '0) || (r_exp == '0)) w_next_state = c_st_done;
        else                              w_next_state = c_st_scan;
      end
      c_st_scan:  if (w_bit) w_next_state = c_st_sqr;
      c_st_sqr:   w_next_state = c_st_sqr_w;
      c_st_sqr_w: if (mm_done) w_next_state = w_bit ? c_st_mul : c_st_next;
      c_st_mul:   w_next_state = c_st_mul_w;
      c_st_mul_w: if (mm_done) w_next_state = c_st_next;
      c_st_next:  w_next_state = (r_idx == '0) ? c_st_done : c_st_sqr;
      c_st_done:  w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    gnt0     = w_take & ~w_pick1;
    gnt1     = w_take & w_pick1;
    done     = (r_state == c_st_done);
    err      = (r_state == c_st_done) & r_err;
    busy     = w_take | (r_state != c_st_idle);
    mm_start = (r_state == c_st_sqr) | (r_state == c_st_mul);
    mm_a     = '0;
    mm_b     = '0;
    // Operands come straight from registers that only change on mm_done,
    // so they stay stable for the whole multiplier wait.
    case (r_state)
      c_st_sqr, c_st_sqr_w: begin
        mm_a = r_acc;
        mm_b = r_acc;
      end
      c_st_mul, c_st_mul_w: begin
        mm_a = r_acc;
        mm_b = r_base;
      end
      default: begin
        mm_a = '0;
        mm_b = '0;
      end
    endcase
  end

  assign result    = r_result;
  assign result_id = r_result_id;
  assign mm_n      = r_n;

  // Datapath: operand capture, accumulator, bit index, result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_exp       <= '0;
      r_n         <= '0;
      r_acc       <= c_one;
      r_idx       <= '0;
      r_id        <= 1'b0;
      r_rr        <= 1'b0;
      r_result    <= '0;
      r_result_id <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_take) begin
            r_base <= w_pick1 ? base1 : base0;
            r_exp  <= w_pick1 ? exp1  : exp0;
            r_n    <= w_pick1 ? mod1  : mod0;
            r_id   <= w_pick1;
            r_idx  <= c_top_idx;
            // Only a contested grant moves the pointer, to the loser.
            if (req0 && req1) r_rr <= ~w_pick1;
          end
        end
        c_st_check: begin
          if (r_n == '0) begin
            r_result    <= '0;
            r_err       <= 1'b1;
            r_result_id <= r_id;
          end else if (r_exp == '0) begin
            r_result    <= (r_n == c_one) ? '0 : c_one;
            r_err       <= 1'b0;
            r_result_id <= r_id;
          end
        end
        c_st_scan: begin
          if (!w_bit) r_idx <= r_idx - c_idx_one;
        end
        c_st_sqr_w, c_st_mul_w: begin
          if (mm_done) r_acc <= mm_result;
        end
        c_st_next: begin
          if (r_idx == '0) begin
            r_result    <= r_acc;
            r_err       <= 1'b0;
            r_result_id <= r_id;
          end else begin
            r_idx <= r_idx - c_idx_one;
          end
        end
        c_st_done: begin
          r_acc <= c_one;
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

`ifdef MODEXP_PERF_CNT_EN
  logic [31:0] r_cnt;
  logic [31:0] r_cycles;

  // During the k-th cycle after the grant r_cnt holds k-1, so the value
  // latched in DONE equals the grant-to-done distance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_cycles <= '0;
    end else begin
      if (w_take) begin
        r_cnt <= '0;
      end else if (busy) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (r_state == c_st_done) r_cycles <= r_cnt + 32'd1;
    end
  end

  assign cycles = r_cycles;
`else
  assign cycles = '0;
`endif

endmodule
`default_nettype wire
